lc3_mem_arbiter: RTL and testbench

//  Shares one unified memory port between LC3 pipeline instruction fetch and the MEM-stage

---
 rtl/lc3_mem_pkg.sv | 18 +
 rtl/lc3_mem_watchdog.sv | 43 ++++
 rtl/lc3_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and default widths for the LC3 unified-memory arbiter.
package lc3_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/lc3_mem_watchdog.sv
// Busy-cycle watchdog: counts cycles while enable is high and flags the
// cycle in which the TIMEOUT-th consecutive enabled cycle is reached.
// TIMEOUT = 0 removes the counter and never flags.
module lc3_mem_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_s;
            assign unused_s = &{1'b0, clk, rst_n, srst, clear, enable};
            assign timeout  = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] cnt_r;

            // Busy-cycle counter, saturating at TIMEOUT, cleared whenever not busy.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (srst || clear) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (enable && (cnt_r != CNT_W'(TIMEOUT))) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end

            // The current cycle is the TIMEOUT-th busy cycle.
            assign timeout = enable && (cnt_r == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbiter sharing one memory port between LC3 instruction fetch and the
// MEM-stage data access. One access at a time: IDLE -> BUSY -> DONE -> IDLE.
// Data normally wins ties; a fetch that has been passed over STARVE_LIMIT
// times wins the next tie.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              srst,
    input  logic              instrmem_rd,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] instr_dout,
    output logic              complete_instr,
    input  logic              Data_en,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    output logic              mem_en,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_complete,
    output logic              mem_err
);

    localparam int                STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_r;
    grant_t              grant_r;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic                busy_s;
    logic                data_win_s;
    logic                wd_timeout_s;

    assign busy_s = (state_r == BUSY);

    lc3_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clock),
        .rst_n   (reset),
        .srst    (srst),
        .clear   (!busy_s),
        .enable  (busy_s),
        .timeout (wd_timeout_s)
    );

    // Data wins any request cycle unless a starved fetch is also waiting.
    always_comb begin
        data_win_s = 1'b0;
        if (Data_en && !(instrmem_rd && (starve_cnt_r == STARVE_MAX))) begin
            data_win_s = 1'b1;
        end else begin
            data_win_s = 1'b0;
        end
    end

    // Arbiter FSM with starvation counter and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            grant_r        <= GNT_INSTR;
            starve_cnt_r   <= {STARVE_W{1'b0}};
            mem_en         <= 1'b0;
            mem_rd         <= 1'b0;
            mem_addr       <= {ADDR_W{1'b0}};
            mem_din        <= {DATA_W{1'b0}};
            instr_dout     <= {DATA_W{1'b0}};
            Data_dout      <= {DATA_W{1'b0}};
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            mem_err        <= 1'b0;
        end else if (srst) begin
            state_r        <= IDLE;
            grant_r        <= GNT_INSTR;
            starve_cnt_r   <= {STARVE_W{1'b0}};
            mem_en         <= 1'b0;
            mem_rd         <= 1'b0;
            mem_addr       <= {ADDR_W{1'b0}};
            mem_din        <= {DATA_W{1'b0}};
            instr_dout     <= {DATA_W{1'b0}};
            Data_dout      <= {DATA_W{1'b0}};
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (data_win_s) begin
                        state_r  <= BUSY;
                        grant_r  <= GNT_DATA;
                        mem_en   <= 1'b1;
                        mem_rd   <= Data_rd;
                        mem_addr <= Data_addr;
                        mem_din  <= Data_rd ? {DATA_W{1'b0}} : Data_din;
                        if (instrmem_rd && (starve_cnt_r != STARVE_MAX)) begin
                            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
                        end
                    end else if (instrmem_rd) begin
                        state_r      <= BUSY;
                        grant_r      <= GNT_INSTR;
                        mem_en       <= 1'b1;
                        mem_rd       <= 1'b1;
                        mem_addr     <= PC;
                        mem_din      <= {DATA_W{1'b0}};
                        starve_cnt_r <= {STARVE_W{1'b0}};
                    end
                end
                BUSY: begin
                    if (mem_complete) begin
                        state_r <= DONE;
                        mem_en  <= 1'b0;
                        if (grant_r == GNT_DATA) begin
                            complete_data <= 1'b1;
                            if (mem_rd) begin
                                Data_dout <= mem_dout;
                            end
                        end else begin
                            complete_instr <= 1'b1;
                            instr_dout     <= mem_dout;
                        end
                    end else if (wd_timeout_s) begin
                        state_r <= DONE;
                        mem_en  <= 1'b0;
                        mem_err <= 1'b1;
                        if (grant_r == GNT_DATA) begin
                            complete_data <= 1'b1;
                            Data_dout     <= {DATA_W{1'b0}};
                        end else begin
                            complete_instr <= 1'b1;
                            instr_dout     <= {DATA_W{1'b0}};
                        end
                    end
                end
                DONE: begin
                    state_r        <= IDLE;
                    complete_instr <= 1'b0;
                    complete_data  <= 1'b0;
                    mem_err        <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    mem_en         <= 1'b0;
                    complete_instr <= 1'b0;
                    complete_data  <= 1'b0;
                    mem_err        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: a table of single accesses plus
// hand-written tie, starvation, watchdog and mid-access reset sequences.
module tb_lc3_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        srst;
    logic        instrmem_rd;
    logic [15:0] PC;
    logic [15:0] instr_dout;
    logic        complete_instr;
    logic        Data_en;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic        mem_en;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_complete;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    bit stall = 1'b0;
    int lat_cnt = 0;

    lc3_mem_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .srst           (srst),
        .instrmem_rd    (instrmem_rd),
        .PC             (PC),
        .instr_dout     (instr_dout),
        .complete_instr (complete_instr),
        .Data_en        (Data_en),
        .Data_rd        (Data_rd),
        .Data_addr      (Data_addr),
        .Data_din       (Data_din),
        .Data_dout      (Data_dout),
        .complete_data  (complete_data),
        .mem_en         (mem_en),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_complete   (mem_complete),
        .mem_err        (mem_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        case (a)
            16'h3000: return 16'h5020;
            16'h4000: return 16'h1111;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    // Memory model: completes a read/write on the 2nd cycle mem_en is seen high.
    initial begin
        mem_complete = 1'b0;
        mem_dout     = 16'hDEAD;
        forever begin
            @(negedge clock);
            if (reset && mem_en && !stall) begin
                lat_cnt++;
                if (lat_cnt >= 2) begin
                    mem_complete = 1'b1;
                    mem_dout     = mem_val(mem_addr);
                end else begin
                    mem_complete = 1'b0;
                    mem_dout     = 16'hDEAD;
                end
            end else begin
                lat_cnt      = 0;
                mem_complete = 1'b0;
                mem_dout     = 16'hDEAD;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the wanted completion pulse, counting mem_en cycles.
    task automatic wait_pulse(input bit want_data, output bit ok, output int n_en,
                              output logic [15:0] first_addr);
        ok = 1'b0;
        n_en = 0;
        first_addr = 16'hxxxx;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            if (mem_en) begin
                if (n_en == 0) first_addr = mem_addr;
                n_en++;
            end
            if (want_data ? complete_data : complete_instr) ok = 1'b1;
        end
    endtask

    typedef struct {
        bit          is_data;
        bit          rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs[7];

    // One isolated access from a table entry; called at a negedge.
    task automatic run_vec(input vec_t v, input int idx);
        bit done;
        int en_cyc;
        done = 1'b0;
        en_cyc = -1;
        if (v.is_data) begin
            Data_en = 1'b1; Data_rd = v.rd; Data_addr = v.addr; Data_din = v.din;
        end else begin
            instrmem_rd = 1'b1; PC = v.addr;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (mem_en && en_cyc < 0) begin
                en_cyc = i;
                chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
                chk($sformatf("v%0d mem_rd", idx), mem_rd, v.is_data ? v.rd : 1'b1);
                if (!v.is_data || !v.rd)
                    chk($sformatf("v%0d mem_din", idx), mem_din, v.is_data ? v.din : 16'h0000);
            end
            if (complete_data || complete_instr) done = 1'b1;
        end
        chk($sformatf("v%0d completed", idx), done, 1'b1);
        chk($sformatf("v%0d grant latency", idx), en_cyc, 0);
        chk($sformatf("v%0d pulse select", idx), {complete_data, complete_instr},
            v.is_data ? 2'b10 : 2'b01);
        chk($sformatf("v%0d mem_en low in done", idx), mem_en, 1'b0);
        chk($sformatf("v%0d dout", idx), v.is_data ? Data_dout : instr_dout, v.exp_dout);
        Data_en = 1'b0;
        instrmem_rd = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d pulse width", idx), {complete_data, complete_instr}, 2'b00);
    endtask

    initial begin
        bit          ok;
        int          n_en;
        int          n_data;
        logic [15:0] faddr;

        vecs[0] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'h5020};
        vecs[1] = '{1'b1, 1'b1, 16'h4000, 16'h0000, 16'h1111};
        vecs[2] = '{1'b1, 1'b0, 16'h4002, 16'h2222, 16'h1111};
        vecs[3] = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'hB791};
        vecs[4] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'hA5A5};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'hABCD, 16'hA5A5};
        vecs[6] = '{1'b1, 1'b1, 16'h00FF, 16'h0000, 16'hA55A};

        reset = 1'b0; srst = 1'b0;
        instrmem_rd = 1'b0; PC = 16'h0000;
        Data_en = 1'b0; Data_rd = 1'b0; Data_addr = 16'h0000; Data_din = 16'h0000;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst mem_en", mem_en, 1'b0);
        chk("rst mem_err", mem_err, 1'b0);
        chk("rst complete_instr", complete_instr, 1'b0);
        chk("rst complete_data", complete_data, 1'b0);
        chk("rst instr_dout", instr_dout, 16'h0000);
        chk("rst Data_dout", Data_dout, 16'h0000);
        chk("rst mem_addr", mem_addr, 16'h0000);
        reset = 1'b1;
        @(negedge clock);
        chk("idle no request", mem_en, 1'b0);

        // Table of isolated accesses
        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Tie: data read and fetch in the same cycle, data first
        instrmem_rd = 1'b1; PC = 16'h3001;
        Data_en = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4000;
        wait_pulse(1'b1, ok, n_en, faddr);
        chk("tie data done", ok, 1'b1);
        chk("tie data first addr", faddr, 16'h4000);
        chk("tie no fetch pulse yet", complete_instr, 1'b0);
        chk("tie Data_dout", Data_dout, 16'h1111);
        Data_en = 1'b0;
        wait_pulse(1'b0, ok, n_en, faddr);
        chk("tie fetch done", ok, 1'b1);
        chk("tie fetch addr", faddr, 16'h3001);
        chk("tie instr_dout", instr_dout, 16'h95A4);
        instrmem_rd = 1'b0;
        @(negedge clock);

        // Starvation: data held continuously with a fetch waiting
        instrmem_rd = 1'b1; PC = 16'h3002;
        Data_en = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4000;
        n_data = 0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            if (complete_data) n_data++;
            if (complete_instr) ok = 1'b1;
        end
        chk("starve fetch done", ok, 1'b1);
        chk("starve data count", n_data, 4);
        chk("starve instr_dout", instr_dout, 16'h95A7);
        instrmem_rd = 1'b0;
        Data_en = 1'b0;
        @(negedge clock);
        chk("starve counter cleared", dut.starve_cnt_r, 0);

        // Watchdog: memory never completes
        stall = 1'b1;
        instrmem_rd = 1'b1; PC = 16'h3010;
        wait_pulse(1'b0, ok, n_en, faddr);
        chk("wd pulse", ok, 1'b1);
        chk("wd busy cycles", n_en, 8);
        chk("wd mem_err", mem_err, 1'b1);
        chk("wd instr_dout forced", instr_dout, 16'h0000);
        instrmem_rd = 1'b0;
        @(negedge clock);
        chk("wd mem_err one cycle", mem_err, 1'b0);
        chk("wd pulse one cycle", complete_instr, 1'b0);

        // Reset during BUSY, then regrant of the held request
        Data_en = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4000;
        repeat (3) @(negedge clock);
        chk("mid pre mem_en", mem_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid rst mem_en", mem_en, 1'b0);
        chk("mid rst mem_addr", mem_addr, 16'h0000);
        chk("mid rst Data_dout", Data_dout, 16'h0000);
        chk("mid rst complete_data", complete_data, 1'b0);
        @(negedge clock);
        stall = 1'b0;
        reset = 1'b1;
        wait_pulse(1'b1, ok, n_en, faddr);
        chk("mid regrant done", ok, 1'b1);
        chk("mid regrant Data_dout", Data_dout, 16'h1111);
        Data_en = 1'b0;
        n_data = 0;
        repeat (6) begin
            @(negedge clock);
            if (complete_data) n_data++;
        end
        chk("mid single pulse", n_data, 0);
        chk("mid no mem_err", mem_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
